mem_bus_lsu: RTL and testbench
==============================

# mem_bus_lsu

Load/store unit for the MEM stage of the MIPS32 pipeline. It consumes the instruction held in the EX/MEM pipeline register and turns memory aluops into a request/acknowledge transaction on the data bus. It requests a pipeline stall until the bus responds, then aligns and extends load data for write-back. Non-memory instructions pass through combinationally with no stall.

## Interface
- No parameters. Widths: data/address 32, register address 5, aluop 8. Aluop encodings come from defines.v.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  exception flush; the current MEM instruction is cancelled
- aluop_i  in  8  MEM-stage aluop
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- wdata_i  in  32  ALU result
- excepttype_i  in  32  nonzero means the instruction already has an exception; the access is suppressed
- wd_o  out  5  equals wd_i
- wreg_o  out  1  write-back enable
- wdata_o  out  32  write-back data
- adel_o, ades_o  out  1  misaligned load / misaligned store flags
- stallreq_o  out  1  MEM-stage stall request
- bus_req_o  out  1  registered request
- bus_we_o  out  1  1 = store
- bus_addr_o  out  32  word address, {addr[31:2],2'b00}
- bus_sel_o  out  4  byte lanes, big-endian (sel[3] is addr[1:0]=00)
- bus_wdata_o  out  32  lane-replicated store data
- bus_ack_i  in  1  one-cycle completion pulse
- bus_rdata_i  in  32  read data, valid with bus_ack_i

## Operation
- Memory ops are LB, LBU, LH, LHU, LW, SB, SH, SW. An op is "valid" when it is a memory op, excepttype_i==0, it is aligned, and flush==0.
- Alignment rules:
  - halfword requires addr[0]=0
  - word requires addr[1:0]=00
  - A violation raises adel_o (loads) or ades_o (stores) combinationally, issues no bus access, forces wreg_o=0, and raises no stall.
- Byte lane select (bus_sel_o):
  - byte: 1000 >> addr[1:0]
  - halfword: 1100 when addr[1]=0, 0011 when addr[1]=1
  - word: 1111
- Store data replication (bus_wdata_o): byte is {4{reg2[7:0]}}, halfword is {2{reg2[15:0]}}, word is reg2.
- State machine: IDLE, REQ, DONE, DRAIN.
  - IDLE, valid op: stallreq_o=1 combinationally. Latch addr, sel, we, wdata into the bus registers. Set bus_req_o and go to REQ.
  - REQ: stallreq_o=1 and bus_req_o held stable.
    - On bus_ack_i: capture bus_rdata_i into rdata_q, clear bus_req_o, go to DONE.
    - On flush with no ack: go to DRAIN.
    - On flush and ack in the same cycle: go to IDLE and discard the data.
  - DONE: stallreq_o=0. wdata_o is the aligned load value taken from rdata_q. The pipeline advances; go to IDLE unconditionally, with no reissue.
  - DRAIN: bus_req_o held until bus_ack_i, then the data is discarded and the state goes to IDLE. stallreq_o=1 only if the new aluop_i is a memory op.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, using the lane selected by addr[1:0] as latched.
- Outputs outside DONE: wdata_o=wdata_i, wreg_o=wreg_i. Exception: a load that is not in DONE drives wreg_o=0.
- A flush in any state clears adel_o/ades_o (they are combinational from inputs, gated by !flush).

## Timing
- Reset values:
  - state IDLE
  - bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0, bus_wdata_o=0
  - rdata_q=0
  - stallreq_o=0
  - wd_o/wreg_o/wdata_o follow inputs; wreg_o is 0 while aluop is NOP
- Reset mid-transaction returns to IDLE immediately. bus_req_o drops the next edge, and any late ack is ignored.
- Minimum memory latency is 3 MEM cycles:
  - T0: IDLE, stall
  - T1: REQ, ack
  - T2: DONE, result
- Each wait cycle with no ack adds one cycle.
- bus_ack_i is ignored in IDLE and DONE.
- Bus outputs change only on the edge that enters REQ. They are stable throughout REQ and DRAIN.
- A non-memory op completes in 0 added cycles.

## Test plan
- LW addr 0x100, memory returns 0xDEADBEEF after 2 wait cycles -> stallreq_o high for 4 cycles, then wdata_o=0xDEADBEEF with wreg_o=1 for exactly one cycle, and bus_req_o pulses once.
- LB addr 0x103 and LBU addr 0x103, rdata 0x112233F0 -> sel 0001; LB gives 0xFFFFFFF0, LBU gives 0x000000F0.
- SH addr 0x202, reg2 0x0000ABCD -> bus_we_o=1, sel 0011, wdata 0xABCDABCD, wreg_o=0.
- LW addr 0x101 -> adel_o=1, bus_req_o stays 0, stallreq_o=0; SW addr 0x102 -> ades_o=1, no access.
- LW issued, flush in the first REQ cycle, ack 3 cycles later while an ADD sits in MEM -> the ADD is not stalled, no write-back of the load data, and the state returns to IDLE after the ack.
- Back-to-back SW then LW, each with ack in its first REQ cycle -> two separate 3-cycle transactions with no duplicate request; rst asserted mid-REQ -> bus_req_o=0 the next cycle.

Source files
------------

// File: rtl/mem_bus_lsu.sv
// MIPS32 MEM-stage load/store unit: memory aluops become one req/ack bus transaction, loads are aligned and extended.
// Latency: 3 cycles minimum (issue, ack, result), plus one per ack wait cycle; the pipeline is held via stallreq_o.
module mem_bus_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] excepttype_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        is_load, is_store, size_b, size_h, size_w;
    logic        is_mem, misalign, op_valid;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size_b   = 1'b0;
        size_h   = 1'b0;
        size_w   = 1'b0;
        case (aluop_i)
            OP_LB, OP_LBU: begin is_load  = 1'b1; size_b = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; size_h = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; size_w = 1'b1; end
            OP_SB:         begin is_store = 1'b1; size_b = 1'b1; end
            OP_SH:         begin is_store = 1'b1; size_h = 1'b1; end
            OP_SW:         begin is_store = 1'b1; size_w = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem   = is_load | is_store;
    assign misalign = (size_h & mem_addr_i[0]) | (size_w & (mem_addr_i[1:0] != 2'b00));
    assign op_valid = is_mem & (excepttype_i == 32'h0) & ~misalign & ~flush;
    assign adel_o   = is_load & misalign & ~flush;
    assign ades_o   = is_store & misalign & ~flush;

    // Big-endian lanes: sel[3] carries byte offset 0.
    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = reg2_i;
        if (size_b) begin
            sel_c   = 4'b1000 >> mem_addr_i[1:0];
            wdata_c = {4{reg2_i[7:0]}};
        end else if (size_h) begin
            sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            wdata_c = {2{reg2_i[15:0]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        addr_lo_d   = addr_lo_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    state_d     = S_REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                    bus_sel_d   = sel_c;
                    bus_wdata_d = wdata_c;
                    addr_lo_d   = mem_addr_i[1:0];
                end
            end
            S_REQ: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        rdata_d = bus_rdata_i;
                        state_d = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_DRAIN: begin
                // The cancelled access must still complete on the bus before a new one may start.
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_sel_q   <= 4'h0;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            addr_lo_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    always_comb begin
        case (addr_lo_q)
            2'b00:   ld_byte = rdata_q[31:24];
            2'b01:   ld_byte = rdata_q[23:16];
            2'b10:   ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = addr_lo_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (aluop_i)
            OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_val = {24'h0, ld_byte};
            OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_val = {16'h0, ld_half};
            default: load_val = rdata_q;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE:  stallreq_o = op_valid;
                S_REQ:   stallreq_o = 1'b1;
                S_DRAIN: stallreq_o = is_mem;
                default: stallreq_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
        if (misalign) begin
            wreg_o = 1'b0;
        end else if (is_load) begin
            if (state_q == S_DONE) begin
                wdata_o = load_val;
            end else begin
                wreg_o = 1'b0;
            end
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_lsu.sv
// Bench for mem_bus_lsu: transaction-level reference model checked every cycle, directed scenarios, then random traffic.
module tb_mem_bus_lsu;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'b00100000;
    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i, excepttype_i, bus_rdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i, bus_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o, adel_o, ades_o, stallreq_o, bus_req_o, bus_we_o;
    logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;

    always #5 clk = ~clk;

    mem_bus_lsu dut (
        .clk(clk), .rst(rst), .flush(flush),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .excepttype_i(excepttype_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .adel_o(adel_o), .ades_o(ades_o), .stallreq_o(stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an outstanding access (possibly abandoned) and a pending result cycle.
    bit          m_busy, m_abandon, m_result;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic [3:0]  m_sel;
    logic        m_we;
    logic [1:0]  m_lo;
    logic        e_stall, e_wreg, e_adel, e_ades, e_valid;
    logic [31:0] e_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic [31:0] extend(input logic [7:0] op, input logic [31:0] rd, input logic [1:0] lo);
        logic [31:0] t;
        int sh;
        sh = (op_size(op) == 1) ? 8 * (3 - int'(lo)) : (lo[1] ? 0 : 16);
        t  = rd >> sh;
        case (op)
            OP_LB:   return {{24{t[7]}}, t[7:0]};
            OP_LBU:  return {24'h0, t[7:0]};
            OP_LH:   return {{16{t[15]}}, t[15:0]};
            OP_LHU:  return {16'h0, t[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic settle_check();
        int  sz;
        bit  ld, mis;
        #1;
        sz  = op_size(aluop_i);
        ld  = op_load(aluop_i);
        mis = (sz == 2 && mem_addr_i[0]) || (sz == 4 && mem_addr_i[1:0] != 2'b00);
        e_valid = (sz != 0) && (excepttype_i == 0) && !mis && !flush;
        e_adel  = ld && mis && !flush;
        e_ades  = !ld && (sz != 0) && mis && !flush;
        if (rst)                      e_stall = 1'b0;
        else if (m_result)            e_stall = 1'b0;
        else if (m_busy && !m_abandon) e_stall = 1'b1;
        else if (m_busy)              e_stall = (sz != 0);
        else                          e_stall = e_valid;
        e_wreg  = mis ? 1'b0 : ((ld && !m_result) ? 1'b0 : wreg_i);
        e_wdata = (m_result && ld) ? extend(aluop_i, m_rdata, m_lo) : wdata_i;
        chk1("stallreq", stallreq_o, e_stall);
        chk1("bus_req", bus_req_o, m_busy);
        chk1("bus_we", bus_we_o, m_we);
        chk("bus_addr", bus_addr_o, m_addr);
        chk("bus_sel", 32'(bus_sel_o), 32'(m_sel));
        chk("bus_wdata", bus_wdata_o, m_wdata);
        chk1("adel", adel_o, e_adel);
        chk1("ades", ades_o, e_ades);
        chk1("wreg", wreg_o, e_wreg);
        chk("wd", 32'(wd_o), 32'(wd_i));
        if (e_wreg) chk("wdata", wdata_o, e_wdata);
    endtask

    task automatic advance();
        int sz;
        @(posedge clk);
        sz = op_size(aluop_i);
        if (rst) begin
            m_busy = 0; m_abandon = 0; m_result = 0;
            m_rdata = 0; m_addr = 0; m_wdata = 0; m_sel = 0; m_we = 0; m_lo = 0;
        end else if (m_result) begin
            m_result = 0;
        end else if (m_busy && !m_abandon) begin
            if (bus_ack_i) begin
                m_busy = 0;
                if (!flush) begin m_result = 1; m_rdata = bus_rdata_i; end
            end else if (flush) begin
                m_abandon = 1;
            end
        end else if (m_busy) begin
            if (bus_ack_i) begin m_busy = 0; m_abandon = 0; end
        end else if (e_valid) begin
            m_busy  = 1;
            m_we    = !op_load(aluop_i);
            m_addr  = {mem_addr_i[31:2], 2'b00};
            m_lo    = mem_addr_i[1:0];
            m_sel   = (sz == 4) ? 4'b1111 : (sz == 2) ? (mem_addr_i[1] ? 4'b0011 : 4'b1100)
                                                      : (4'b1000 >> mem_addr_i[1:0]);
            m_wdata = (sz == 4) ? reg2_i : (sz == 2) ? {2{reg2_i[15:0]}} : {4{reg2_i[7:0]}};
        end
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                             input logic wr, input logic [31:0] wd);
        aluop_i = op; mem_addr_i = addr; reg2_i = r2; wreg_i = wr; wdata_i = wd;
        wd_i = 5'd7; excepttype_i = 0; flush = 0; rst = 0;
    endtask

    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                           input int waits, input logic [31:0] rd,
                           output int stalls, output int reqs, output logic [31:0] res,
                           output logic res_wreg, output logic [3:0] sel,
                           output logic [31:0] bwd, output logic we);
        int   w;
        logic prev_req;
        set_instr(op, addr, r2, op_load(op), 32'h0BAD0BAD);
        bus_rdata_i = rd;
        stalls = 0; reqs = 0; w = 0; prev_req = 1'b0;
        res = 0; res_wreg = 0; sel = 0; bwd = 0; we = 0;
        for (int i = 0; i < 30; i++) begin
            bus_ack_i = m_busy && (w == waits);
            if (m_busy) w++;
            settle_check();
            if (stallreq_o) stalls++;
            if (bus_req_o && !prev_req) begin
                reqs++; sel = bus_sel_o; bwd = bus_wdata_o; we = bus_we_o;
            end
            prev_req = bus_req_o;
            if (m_result) begin
                res = wdata_o; res_wreg = wreg_o;
                advance();
                bus_ack_i = 0;
                return;
            end
            advance();
        end
        checks++; errors++;
        $display("FAIL run_mem_timeout: no result within 30 cycles for op %h", op);
        bus_ack_i = 0;
    endtask

    task automatic new_instr();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0: aluop_i = OP_NOP; 1: aluop_i = OP_ADD; 2: aluop_i = OP_LB; 3: aluop_i = OP_LBU;
            4: aluop_i = OP_LH;  5: aluop_i = OP_LHU; 6: aluop_i = OP_LW; 7: aluop_i = OP_SB;
            8: aluop_i = OP_SH;  default: aluop_i = OP_SW;
        endcase
        mem_addr_i = $urandom;
        if ($urandom_range(0, 1) == 0) mem_addr_i[1:0] = 2'b00;
        reg2_i  = $urandom;
        wdata_i = $urandom;
        wd_i    = 5'($urandom);
        if (op_load(aluop_i))          wreg_i = 1'b1;
        else if (aluop_i == OP_ADD)    wreg_i = 1'($urandom);
        else                           wreg_i = 1'b0;
        excepttype_i = ($urandom_range(0, 9) == 0) ? 32'h8 : 32'h0;
    endtask

    initial begin
        int          stalls, reqs, wait_cnt;
        logic [31:0] res, bwd;
        logic        res_wreg, we, adv;
        logic [3:0]  sel;

        set_instr(OP_NOP, 0, 0, 1'b0, 32'h55);
        rst = 1; bus_ack_i = 0; bus_rdata_i = 0;
        advance();
        settle_check();
        chk1("reset_bus_req", bus_req_o, 1'b0);
        chk("reset_bus_addr", bus_addr_o, 32'h0);
        chk("reset_bus_sel", 32'(bus_sel_o), 32'h0);
        chk1("reset_stall", stallreq_o, 1'b0);
        chk1("reset_nop_wreg", wreg_o, 1'b0);
        advance();
        rst = 0;

        // LW with two wait cycles.
        run_mem(OP_LW, 32'h100, 0, 2, 32'hDEADBEEF, stalls, reqs, res, res_wreg, sel, bwd, we);
        chk("lw_stall_cycles", stalls, 4);
        chk("lw_req_pulses", reqs, 1);
        chk("lw_result", res, 32'hDEADBEEF);
        chk1("lw_result_wreg", res_wreg, 1'b1);
        chk("lw_sel", 32'(sel), 32'hF);
        set_instr(OP_NOP, 0, 0, 1'b0, 0);
        settle_check();
        chk1("lw_wreg_one_cycle", wreg_o, 1'b0);
        advance();

        run_mem(OP_LB, 32'h103, 0, 0, 32'h112233F0, stalls, reqs, res, res_wreg, sel, bwd, we);
        chk("lb_sel", 32'(sel), 32'h1);
        chk("lb_result", res, 32'hFFFFFFF0);
        run_mem(OP_LBU, 32'h103, 0, 1, 32'h112233F0, stalls, reqs, res, res_wreg, sel, bwd, we);
        chk("lbu_result", res, 32'h000000F0);
        run_mem(OP_LH, 32'h102, 0, 0, 32'h1234_8001, stalls, reqs, res, res_wreg, sel, bwd, we);
        chk("lh_result", res, 32'hFFFF8001);

        run_mem(OP_SH, 32'h202, 32'h0000ABCD, 0, 0, stalls, reqs, res, res_wreg, sel, bwd, we);
        chk1("sh_we", we, 1'b1);
        chk("sh_sel", 32'(sel), 32'h3);
        chk("sh_wdata", bwd, 32'hABCDABCD);
        chk1("sh_wreg", res_wreg, 1'b0);

        // Misaligned accesses raise the flag and never reach the bus.
        set_instr(OP_LW, 32'h101, 0, 1'b1, 0);
        settle_check();
        chk1("lw_misaligned_adel", adel_o, 1'b1);
        chk1("lw_misaligned_stall", stallreq_o, 1'b0);
        advance();
        settle_check();
        chk1("lw_misaligned_noreq", bus_req_o, 1'b0);
        set_instr(OP_SW, 32'h102, 0, 1'b0, 0);
        settle_check();
        chk1("sw_misaligned_ades", ades_o, 1'b1);
        advance();
        settle_check();
        chk1("sw_misaligned_noreq", bus_req_o, 1'b0);
        advance();

        // Flush during the first REQ cycle; unrelated ADDs must flow while the bus drains.
        set_instr(OP_LW, 32'h100, 0, 1'b1, 0);
        bus_rdata_i = 32'h77777777;
        settle_check();
        advance();
        flush = 1;
        settle_check();
        chk1("flush_req_stall", stallreq_o, 1'b1);
        advance();
        set_instr(OP_ADD, 0, 0, 1'b1, 32'h1234);
        for (int k = 0; k < 3; k++) begin
            bus_ack_i = (k == 2);
            settle_check();
            chk1("drain_add_nostall", stallreq_o, 1'b0);
            chk("drain_add_wdata", wdata_o, 32'h1234);
            advance();
        end
        bus_ack_i = 0;
        settle_check();
        chk1("drain_done_noreq", bus_req_o, 1'b0);
        advance();

        // Back-to-back SW then LW, each acked in its first REQ cycle.
        run_mem(OP_SW, 32'h300, 32'h11223344, 0, 0, stalls, reqs, res, res_wreg, sel, bwd, we);
        chk("sw_stall_cycles", stalls, 2);
        chk("sw_req_pulses", reqs, 1);
        chk("sw_wdata", bwd, 32'h11223344);
        run_mem(OP_LW, 32'h304, 0, 0, 32'hCAFEF00D, stalls, reqs, res, res_wreg, sel, bwd, we);
        chk("lw2_stall_cycles", stalls, 2);
        chk("lw2_req_pulses", reqs, 1);
        chk("lw2_result", res, 32'hCAFEF00D);

        // Reset while a request is outstanding; a late ack must be ignored.
        set_instr(OP_LW, 32'h400, 0, 1'b1, 0);
        settle_check();
        advance();
        rst = 1;
        settle_check();
        advance();
        set_instr(OP_NOP, 0, 0, 1'b0, 0);
        bus_ack_i = 1;
        settle_check();
        chk1("rst_midreq_req_dropped", bus_req_o, 1'b0);
        advance();
        bus_ack_i = 0;
        settle_check();
        chk1("rst_late_ack_ignored", bus_req_o, 1'b0);
        advance();

        // Random traffic with flushes, resets, wait states and stray acks.
        adv = 1;
        wait_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (adv) new_instr();
            flush = ($urandom_range(0, 11) == 0);
            rst   = ($urandom_range(0, 79) == 0);
            if (m_busy) begin
                if (wait_cnt == 0) bus_ack_i = 1'b1;
                else begin bus_ack_i = 1'b0; wait_cnt--; end
            end else begin
                bus_ack_i = ($urandom_range(0, 7) == 0);
                wait_cnt  = $urandom_range(0, 3);
            end
            bus_rdata_i = $urandom;
            settle_check();
            adv = !e_stall || flush || rst;
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
